// File: rtl/mult_shift_add_ctrl_if.sv
// Handshake bundle between the shift-add multiplier and its surroundings:
// operand request (Start/A/B), the iteration-counter link (Load/K) and
// the result side (Busy/Done/P).
interface mult_shift_add_ctrl_if #(
  parameter int N = 4
);
  logic           Start;
  logic [N-1:0]   A;
  logic [N-1:0]   B;
  logic           K;
  logic           Load;
  logic           Busy;
  logic           Done;
  logic [2*N-1:0] P;

  // Multiplier side: takes requests and the counter flag, drives status and product
  modport slave (
    input  Start, A, B, K,
    output Load, Busy, Done, P
  );

  // Requester / environment side
  modport master (
    output Start, A, B, K,
    input  Load, Busy, Done, P
  );
endinterface

// File: rtl/mult_shift_add_ctrl.sv
// Sequential unsigned shift-add multiplier. One add/shift step per clock
// while in RUN; the external iteration counter (reloaded by Load, flagging
// the final step with K) decides when the product is complete.
module mult_shift_add_ctrl #(
  parameter int N = 4
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  mult_shift_add_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [2*N-1:0] p_q, p_d;
  logic [N-1:0]   m_q, m_d;
  // N+1-bit partial sum: the top bit is the add carry, kept through the shift
  logic [N:0]     sum;

  // State and datapath registers; asynchronous abort back to an empty IDLE
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      m_q     <= m_d;
    end
  end

  // Next-state, datapath step and Moore-decoded outputs
  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    m_d      = m_q;
    bus.Load = 1'b1;
    bus.Busy = 1'b0;
    bus.Done = 1'b0;

    // Add the multiplicand only when the current multiplier bit is set
    if (p_q[0]) begin
      sum = {1'b0, p_q[2*N-1:N]} + {1'b0, m_q};
    end else begin
      sum = {1'b0, p_q[2*N-1:N]};
    end

    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          m_d     = bus.A;
          p_d     = {{N{1'b0}}, bus.B};
          state_d = RUN;
        end
      end
      RUN: begin
        bus.Load = 1'b0;
        bus.Busy = 1'b1;
        // Shift the carry-extended sum down into the product register
        p_d      = {sum, p_q[N-1:1]};
        // K marks the last step; an early K simply truncates the product
        if (bus.K) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bus.Done = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.P = p_q;

endmodule

// File: tb/tb_mult_shift_add_ctrl.sv
// Directed bench for the shift-add multiplier with a behavioural iteration
// counter that raises K on a programmable count cycle.
`timescale 1ns/1ps
module tb_mult_shift_add_ctrl;
  localparam int N = 4;

  logic Clk;
  logic Rst_n;
  int   pass_cnt;
  int   total_cnt;
  int   k_at;
  logic [3:0] cnt_q;

  mult_shift_add_ctrl_if #(.N(N)) bus ();

  mult_shift_add_ctrl #(.N(N)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Counter model: reload while Load=1, count otherwise, K on the k_at-th count cycle
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)        cnt_q <= '0;
    else if (bus.Load) cnt_q <= '0;
    else               cnt_q <= cnt_q + 4'd1;
  end
  assign bus.K = !bus.Load && (int'(cnt_q) == k_at - 1);

  // Launch one operation and observe it; Start is optionally held high
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic hold,
                        output int busy_n, output int load0_n, output int lat,
                        output logic [7:0] prod);
    busy_n = 0; load0_n = 0; lat = 0; prod = '0;
    bus.Start = 1'b1; bus.A = a; bus.B = b;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge Clk);
      if (cyc == 1 && !hold) bus.Start = 1'b0;
      if (bus.Busy) busy_n++;
      if (!bus.Load) load0_n++;
      if (bus.Done) begin
        lat = cyc; prod = bus.P;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.Start = 1'b0; bus.A = '0; bus.B = '0;
    Rst_n = 1'b0;
    repeat (2) @(negedge Clk);
    total_cnt++;
    if ({bus.P, bus.Busy, bus.Done, bus.Load} !== {8'h00, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_state: P=%h Busy=%b Done=%b Load=%b, required P=00 Busy=0 Done=0 Load=1",
               bus.P, bus.Busy, bus.Done, bus.Load);
    else pass_cnt++;
    Rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      total_cnt++;
      if ({bus.P, bus.Busy, bus.Done, bus.Load} !== {8'h00, 1'b0, 1'b0, 1'b1})
        $display("FAIL idle_hold[%0d]: P=%h Busy=%b Done=%b Load=%b, required 00/0/0/1",
                 i, bus.P, bus.Busy, bus.Done, bus.Load);
      else pass_cnt++;
    end
    $display("reset: idle outputs checked for 10 cycles");
  endtask

  task automatic test_basic();
    int bn, ln, lat; logic [7:0] p;
    run_op(4'd13, 4'd11, 1'b0, bn, ln, lat, p);
    total_cnt++;
    if (p !== 8'h8F || lat != 5 || bn != 4 || ln != 4)
      $display("FAIL basic_13x11: P=%h lat=%0d busy=%0d load0=%0d, required P=8f lat=5 busy=4 load0=4",
               p, lat, bn, ln);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      total_cnt++;
      if (bus.P !== 8'h8F || bus.Busy !== 1'b0 || bus.Done !== 1'b0)
        $display("FAIL basic_hold[%0d]: P=%h Busy=%b Done=%b, required P=8f Busy=0 Done=0",
                 i, bus.P, bus.Busy, bus.Done);
      else pass_cnt++;
    end
    $display("basic: 13*11 -> P=%h lat=%0d", p, lat);
  endtask

  task automatic test_carry_zero();
    logic [3:0] av [4] = '{4'd15, 4'd0, 4'd7, 4'd1};
    logic [3:0] bv [4] = '{4'd15, 4'd9, 4'd0, 4'd15};
    logic [7:0] ev [4] = '{8'hE1, 8'h00, 8'h00, 8'h0F};
    int bn, ln, lat; logic [7:0] p;
    for (int i = 0; i < 4; i++) begin
      run_op(av[i], bv[i], 1'b0, bn, ln, lat, p);
      @(negedge Clk);
      total_cnt++;
      if (p !== ev[i] || lat != 5)
        $display("FAIL carry_zero_%0dx%0d: P=%h lat=%0d, required P=%h lat=5", av[i], bv[i], p, lat, ev[i]);
      else pass_cnt++;
      $display("carry_zero: %0d*%0d -> P=%h", av[i], bv[i], p);
    end
  endtask

  task automatic test_start_ignored();
    int bn, lat; logic [7:0] p;
    bn = 0; lat = 0; p = '0;
    bus.Start = 1'b1; bus.A = 4'd5; bus.B = 4'd6;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge Clk);
      bus.A = 4'd9; bus.B = 4'd9;   // Start stays high through RUN and DONE
      if (bus.Busy) bn++;
      if (bus.Done) begin lat = cyc; p = bus.P; break; end
    end
    total_cnt++;
    if (p !== 8'h1E || bn != 4 || lat != 5)
      $display("FAIL start_ignored: P=%h busy=%0d lat=%0d, required P=1e busy=4 lat=5", p, bn, lat);
    else pass_cnt++;
    @(negedge Clk);
    total_cnt++;
    if (bus.Busy !== 1'b0 || bus.P !== 8'h1E)
      $display("FAIL start_ignored_idle_gap: Busy=%b P=%h, required Busy=0 P=1e", bus.Busy, bus.P);
    else pass_cnt++;
    bus.Start = 1'b0;
    @(negedge Clk);
    $display("start_ignored: 5*6 -> P=%h", p);
  endtask

  task automatic test_reset_mid();
    int bn, ln, lat; logic [7:0] p;
    bus.Start = 1'b1; bus.A = 4'd13; bus.B = 4'd11;
    @(negedge Clk); bus.Start = 1'b0;      // 1st RUN cycle
    @(negedge Clk);                        // 2nd RUN cycle
    Rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({bus.P, bus.Busy, bus.Done, bus.Load} !== {8'h00, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_mid_async: P=%h Busy=%b Done=%b Load=%b, required 00/0/0/1",
               bus.P, bus.Busy, bus.Done, bus.Load);
    else pass_cnt++;
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    run_op(4'd3, 4'd4, 1'b0, bn, ln, lat, p);
    total_cnt++;
    if (p !== 8'h0C || lat != 5 || bn != 4)
      $display("FAIL reset_mid_restart: P=%h lat=%0d busy=%0d, required P=0c lat=5 busy=4", p, lat, bn);
    else pass_cnt++;
    @(negedge Clk);
    $display("reset_mid: restart 3*4 -> P=%h", p);
  endtask

  task automatic test_back_to_back();
    int bn, ln, lat; logic [7:0] p;
    run_op(4'd2, 4'd3, 1'b1, bn, ln, lat, p);   // Start left high
    total_cnt++;
    if (p !== 8'h06 || lat != 5)
      $display("FAIL b2b_first: P=%h lat=%0d, required P=06 lat=5", p, lat);
    else pass_cnt++;
    @(negedge Clk);                              // the single IDLE cycle
    bus.A = 4'd4; bus.B = 4'd4;
    total_cnt++;
    if (bus.Busy !== 1'b0 || bus.Load !== 1'b1)
      $display("FAIL b2b_idle_gap: Busy=%b Load=%b, required Busy=0 Load=1", bus.Busy, bus.Load);
    else pass_cnt++;
    bn = 0; lat = 0; p = '0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge Clk);
      if (cyc == 1) begin
        total_cnt++;
        if (bus.Busy !== 1'b1)
          $display("FAIL b2b_restart: Busy=%b, required 1", bus.Busy);
        else pass_cnt++;
        bus.Start = 1'b0;
      end
      if (bus.Busy) bn++;
      if (bus.Done) begin lat = cyc; p = bus.P; break; end
    end
    total_cnt++;
    if (p !== 8'h10 || lat != 5 || bn != 4)
      $display("FAIL b2b_second: P=%h lat=%0d busy=%0d, required P=10 lat=5 busy=4", p, lat, bn);
    else pass_cnt++;
    $display("back_to_back: 2*3 then 4*4 -> P=%h", p);
    @(negedge Clk);
    // Early K: 15*15 stopped after 2 steps: 0x0F -> 0x7F -> 0xB7
    k_at = 2;
    run_op(4'd15, 4'd15, 1'b0, bn, ln, lat, p);
    total_cnt++;
    if (p !== 8'hB7 || lat != 3 || bn != 2)
      $display("FAIL early_k: P=%h lat=%0d busy=%0d, required P=b7 lat=3 busy=2", p, lat, bn);
    else pass_cnt++;
    k_at = N;
    @(negedge Clk);
    $display("early_k: truncated 15*15 -> P=%h", p);
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0; k_at = N;
    Rst_n = 1'b1;
    bus.Start = 1'b0; bus.A = '0; bus.B = '0;
    @(negedge Clk);
    test_reset();
    test_basic();
    test_carry_zero();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
